// File: rtl/lzd_norm_pipe.sv
// rtl/lzd_norm_pipe.sv - two-stage leading-zero count and normalise pipeline
// S1 registers operand + LZD-tree count, S2 registers the barrel-shifted result.
module lzd_norm_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_lzc,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  // Tree of 2-bit LZD cells, then merges pairing (hi, lo) nodes level by level.
  // Node i of a level covers the i-th slice counted from the LSB end.
  function automatic logic [CW-1:0] lzd_tree(input logic [WIDTH-1:0] d);
    logic [CW-1:0] cnt [WIDTH/2];
    logic          vld [WIDTH/2];
    for (int i = 0; i < WIDTH/2; i++) begin
      vld[i] = d[2*i+1] | d[2*i];
      cnt[i] = {{(CW-1){1'b0}}, ~d[2*i+1]};
    end
    for (int l = 1; l < CW; l++) begin
      for (int i = 0; i < (WIDTH >> (l+1)); i++) begin
        cnt[i] = vld[2*i+1] ? cnt[2*i+1] : (cnt[2*i] | (CW'(1) << l));
        vld[i] = vld[2*i+1] | vld[2*i];
      end
    end
    return vld[0] ? cnt[0] : '0;
  endfunction

  logic             s1_v;
  logic [WIDTH-1:0] s1_data;
  logic [CW-1:0]    s1_lzc;
  logic             s1_zero;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_load;
  logic             s2_load;

  assign s2_load  = s1_v & (~out_valid | out_ready);
  assign in_ready = ~s1_v | s2_load;
  assign s1_load  = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_data <= '0;
      s1_lzc  <= '0;
      s1_zero <= 1'b0;
      s1_tag  <= '0;
    end else if (s1_load) begin
      s1_v    <= 1'b1;
      s1_data <= in_data;
      s1_lzc  <= lzd_tree(in_data);
      s1_zero <= ~|in_data;
      s1_tag  <= in_tag;
    end else if (s2_load) begin
      s1_v    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lzc   <= '0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_data  <= s1_data << s1_lzc;
      out_lzc   <= s1_lzc;
      out_zero  <= s1_zero;
      out_tag   <= s1_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lzd_norm_pipe.sv
// tb/tb_lzd_norm_pipe.sv - randomized scoreboard bench for lzd_norm_pipe
module tb_lzd_norm_pipe;
  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int CW    = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_lzc;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    l;
    logic             z;
    logic [TAG_W-1:0] t;
  } res_t;

  res_t exp_q[$];
  res_t prev;
  logic prev_hold = 1'b0;

  lzd_norm_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lzc(out_lzc), .out_zero(out_zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Reference: count zeros from the MSB, shift left by that amount.
  function automatic res_t ref_model(input logic [WIDTH-1:0] d, input logic [TAG_W-1:0] t);
    res_t r;
    int   n = 0;
    while (n < WIDTH && d[WIDTH-1-n] == 1'b0) n++;
    r.z = (d == '0);
    r.l = r.z ? '0 : CW'(n);
    r.d = r.z ? '0 : (d << n);
    r.t = t;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_data();
    if ($urandom_range(9) == 0) return '0;
    return WIDTH'($urandom >> $urandom_range(31));
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and hold-stability monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) check("hold_stable", {out_data, out_lzc, out_zero, out_tag}, prev);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", 1, 0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("result", {out_data, out_lzc, out_zero, out_tag}, e);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_model(in_data, in_tag));
      prev_hold = out_valid && !out_ready;
      prev = {out_data, out_lzc, out_zero, out_tag};
    end
  end

  task automatic send_one(input logic [WIDTH-1:0] d, input logic [TAG_W-1:0] t,
                          input logic [WIDTH-1:0] ed, input int el, input logic ez);
    in_valid = 1'b1; in_data = d; in_tag = t; out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_early", out_valid, 0);
    @(negedge clk);
    check("latency_valid", out_valid, 1);
    check("single_data", out_data, ed);
    check("single_lzc", out_lzc, el);
    check("single_zero", out_zero, ez);
    check("single_tag", out_tag, t);
    tick();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_valid", out_valid, 0);
  endtask

  initial begin
    int cnt;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_lzc", out_lzc, 0);
    check("rst_out_zero", out_zero, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    send_one(32'h0001_0000, 4'd3, 32'h8000_0000, 15, 1'b0);
    send_one(32'h0000_0000, 4'd7, 32'h0000_0000, 0, 1'b1);
    send_one(32'h8000_0001, 4'd1, 32'h8000_0001, 0, 1'b0);
    send_one(32'h0000_0001, 4'd2, 32'h8000_0000, 31, 1'b0);

    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'b1; in_data = rnd_data(); in_tag = TAG_W'($urandom);
      @(negedge clk);
      check("stream_in_ready", in_ready, 1);
      tick();
    end
    drain();

    out_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = rnd_data(); in_tag = TAG_W'($urandom);
      @(negedge clk);
      if (in_ready) cnt++;
      tick();
    end
    check("stall_accepts", cnt, 2);
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    drain();

    for (int i = 0; i < 5000; i++) begin
      in_valid = $urandom_range(1) == 1;
      out_ready = $urandom_range(1) == 1;
      in_data = rnd_data(); in_tag = TAG_W'($urandom);
      tick();
    end
    drain();

    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = rnd_data() | 32'h1; in_tag = TAG_W'($urandom);
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_lzc", out_lzc, 0);
    check("mid_rst_zero", out_zero, 0);
    check("mid_rst_tag", out_tag, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    #3 rst_n = 1'b1;
    tick();
    send_one(32'h0000_0400, 4'd5, 32'h8000_0000, 21, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/lzd_norm_pipe.md
# lzd_norm_pipe

Two-stage pipelined leading-zero count and normalise unit for the arithmetic datapath. It counts the leading zeros of a WIDTH-bit operand, a tree of 2-bit LZD cells plus merge units, and left-shifts the operand so its MSB is 1. It sits directly downstream of the raw mantissa source and feeds the rounding/exponent-adjust stage. Both ports use valid/ready handshakes with full backpressure, and throughput is one operand per clock.

## Interface
- WIDTH, 32, operand width; power of two, 4..64
- TAG_W, 4, sideband tag width, carried unmodified
- CW (localparam), log2(WIDTH), count width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand offered
- in_ready  out  1  block can accept
- in_data  in  WIDTH  operand
- in_tag  in  TAG_W  sideband
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_data  out  WIDTH  normalised operand
- out_lzc  out  CW  leading-zero count / shift amount
- out_zero  out  1  operand was all zeros
- out_tag  out  TAG_W  sideband of this result

One clock; reset is asynchronous and active-low (clk, rst_n).

## Operation
- **Stage 1 (S1)**
  - Registers in_data and in_tag.
  - Registers lzc, the number of consecutive zero bits starting at in_data[WIDTH-1].
  - Registers zero = ~|in_data.
  - lzc comes from a combinational log-tree of LZD 2-bit cells and merge cells.
- **Stage 2 (S2)**
  - Registers out_data = s1_data << s1_lzc, with zeros shifted in.
  - Registers out_lzc = s1_lzc, out_zero = s1_zero, out_tag = s1_tag.
- **All-zero operand:** out_data = 0, out_lzc = 0, out_zero = 1.
- **Any non-zero operand:** out_data[WIDTH-1] = 1, out_zero = 0, out_lzc ranges 0..WIDTH-1.
- **Handshake:**
  - s2_load = s1_v & (~out_valid | out_ready).
  - s1_load = in_valid & in_ready.
  - in_ready = ~s1_v | s2_load. This is combinational; it has no path from in_valid.
- **Valid flags:**
  - s1_v is set by s1_load. It is cleared when s2_load occurs without s1_load in the same cycle.
  - out_valid is set by s2_load. It is cleared when out_ready is high and no s2_load occurs in the same cycle.
- **Simultaneous events:** S1 may load a new operand on the same edge it hands its old contents to S2. Likewise, S2 may load on the same edge it is consumed.
- **Holding:** while out_valid & ~out_ready, every out_* signal holds stable. S1 holds its contents until S2 frees.
- **Capacity and ordering:** capacity is 2 operands. Ordering is strict FIFO. There is no drop and no duplication.
- **Reset:** asserting rst_n low at any time clears s1_v and out_valid and zeros all data, lzc, zero and tag registers. Results in flight are discarded, with no partial output.

## Timing
- **Reset values:**
  - out_valid = 0, out_data = 0, out_lzc = 0, out_zero = 0, out_tag = 0.
  - in_ready = 1, because s1_v = 0.
- **Latency:** an operand accepted on edge N appears with out_valid = 1 after edge N+1, provided out_valid was 0 or out_ready was 1 at edge N+1.
- **Throughput:** with out_ready held high, one result per cycle and in_ready stays 1.
- **Backpressure:**
  - With out_ready = 0 from idle, the first operand reaches S2 and the second sits in S1.
  - in_ready is then 0 until out_ready rises.
  - in_ready returns to 1 combinationally in the same cycle that out_ready = 1.
- **Inputs ignored:** in_data and in_tag are ignored when in_valid & in_ready is 0.
- **Critical path:** LZD tree in S1 and barrel shifter in S2. There is no combinational path from in_* to out_*.

## Test plan
- **Single operand:** in_data = 32'h0001_0000, tag 3, out_ready = 1 → out_valid one cycle after acceptance with out_data = 32'h8000_0000, out_lzc = 15, out_zero = 0, out_tag = 3.
- **Edge operands:** 32'h0000_0000 → out_data 0, out_lzc 0, out_zero 1. 32'h8000_0001 → unchanged, lzc 0. 32'h0000_0001 → 32'h8000_0000, lzc 31.
- **Streaming:** 1000 random operands, including 10% zeros, back to back with out_ready = 1 → one result per cycle, in_ready constantly 1, results match the reference model in order.
- **Stall fill:** out_ready = 0, in_valid = 1 from idle → exactly 2 acceptances, then in_ready = 0. out_* stays stable for 20 cycles. On out_ready = 1, both results drain in order and in_ready rises in the same cycle.
- **Random handshake:** random in_valid and out_ready (50%) over 5000 cycles → scoreboard shows no loss, no duplication, order preserved. Assertion: out_* stable while out_valid & ~out_ready.
- **Mid-operation reset:** pulse rst_n low asynchronously (mid-cycle) with 2 operands in flight → out_valid drops immediately, all outputs read 0, in_ready = 1. The first operand after release yields a correct result with no stale output.
